// File: rtl/seq_multiplier_pkg.sv
// Shared constants for the iterative multiplier and the ALU that hosts it:
// FSM state encoding and flag bit positions.
package seq_multiplier_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_W    = 3;

endpackage

// File: rtl/mult_flag_gen.sv
// Zero / negative / overflow flags for a 2*WIDTH-bit product.
// Overflow means the product does not fit back into WIDTH bits in the given mode.
module mult_flag_gen
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] result,
    input  logic               signed_mode,
    output logic [FLAG_W-1:0]  flags
);

    always_comb begin
        flags            = '0;
        flags[FLAG_ZERO] = (result == '0);
        flags[FLAG_NEG]  = result[2*WIDTH-1];
        if (signed_mode)
            flags[FLAG_OVF] = (result[2*WIDTH-1:WIDTH] != {WIDTH{result[WIDTH-1]}});
        else
            flags[FLAG_OVF] = |result[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier with start/busy/done handshake. Signed operands
// are multiplied as magnitudes and the product sign is restored in FIX.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   primary_operand,
    input  logic [WIDTH-1:0]   secondary_operand,
    input  logic               oe,
    output logic               busy,
    output logic               done,
    output logic [FLAG_W-1:0]  flags,
    output logic [2*WIDTH-1:0] mult_out
);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_neg_q, sign_neg_d;
    logic               mode_q, mode_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               res_mode_q, res_mode_d;
    logic [WIDTH:0]     add_sum;
    logic [FLAG_W-1:0]  flags_int;

    // Most-negative input maps to 2^(WIDTH-1), which is still a valid unsigned pattern.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // Upper half plus multiplicand, carry kept so the shift brings it back in.
    assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sign_neg_d = sign_neg_q;
        mode_d     = mode_q;
        res_d      = res_q;
        res_mode_d = res_mode_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mcand_d    = magnitude(primary_operand, signed_mode);
                    acc_d      = {{WIDTH{1'b0}}, magnitude(secondary_operand, signed_mode)};
                    cnt_d      = CNT_W'(WIDTH);
                    sign_neg_d = signed_mode & (primary_operand[WIDTH-1] ^ secondary_operand[WIDTH-1]);
                    mode_d     = signed_mode;
                    state_d    = ST_RUN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1))
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                res_d      = sign_neg_q ? (~acc_q + 1'b1) : acc_q;
                res_mode_d = mode_q;
                state_d    = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mcand_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sign_neg_q <= 1'b0;
            mode_q     <= 1'b0;
            res_q      <= '0;
            res_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sign_neg_q <= sign_neg_d;
            mode_q     <= mode_d;
            res_q      <= res_d;
            res_mode_q <= res_mode_d;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign done = (state_q == ST_DONE);

    mult_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result      (res_q),
        .signed_mode (res_mode_q),
        .flags       (flags_int)
    );

    // Shared ALU buses: only drive while selected.
    assign mult_out = oe ? res_q     : 'z;
    assign flags    = oe ? flags_int : 'z;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH=8 and WIDTH=16 against an integer-arithmetic
// model of the product and its flags.
module tb_seq_multiplier;

    logic        clock, reset;
    logic        start8, sm8, oe8, start16, sm16, oe16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    wire         busy8, done8, busy16, done16;
    wire  [2:0]  flags8, flags16;
    wire  [15:0] out8;
    wire  [31:0] out16;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_p [2];
    logic [2:0]  exp_f [2];
    logic [31:0] prev_p [2];

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .signed_mode(sm8),
        .primary_operand(a8), .secondary_operand(b8), .oe(oe8),
        .busy(busy8), .done(done8), .flags(flags8), .mult_out(out8)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .signed_mode(sm16),
        .primary_operand(a16), .secondary_operand(b16), .oe(oe16),
        .busy(busy16), .done(done16), .flags(flags16), .mult_out(out16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int wid(input int sel);
        return sel ? 16 : 8;
    endfunction

    function automatic logic [31:0] get_out(input int sel);
        return sel ? out16 : {16'h0, out8};
    endfunction

    function automatic logic [2:0] get_flags(input int sel);
        return sel ? flags16 : flags8;
    endfunction

    function automatic logic get_busy(input int sel);
        return sel ? busy16 : busy8;
    endfunction

    function automatic logic get_done(input int sel);
        return sel ? done16 : done8;
    endfunction

    // Reference: exact integer product, flags from value ranges.
    task automatic model(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] p, output logic [2:0] f);
        longint m, va, vb, prod, lim;
        m  = (longint'(1) << w) - 1;
        va = longint'(a) & m;
        vb = longint'(b) & m;
        if (s && a[w-1]) va = va - (longint'(1) << w);
        if (s && b[w-1]) vb = vb - (longint'(1) << w);
        prod = va * vb;
        p    = 32'(prod & ((longint'(1) << (2*w)) - 1));
        lim  = longint'(1) << (w-1);
        f[0] = (prod == 0);
        f[1] = p[2*w-1];
        f[2] = s ? (prod < -lim || prod > lim - 1) : (prod > m);
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start8 = v; else start16 = v;
    endtask

    task automatic issue(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b);
        prev_p[sel] = exp_p[sel];
        model(wid(sel), s, a, b, exp_p[sel], exp_f[sel]);
        if (sel == 0) begin
            a8 = a[7:0]; b8 = b[7:0]; sm8 = s; start8 = 1'b1;
        end else begin
            a16 = a[15:0]; b16 = b[15:0]; sm16 = s; start16 = 1'b1;
        end
    endtask

    // Leaves the bench in the DONE cycle; optionally pokes start while busy.
    task automatic wait_done(input int sel, input logic poke);
        int n, bc;
        logic oe_now;
        tick();
        set_start(sel, 1'b0);
        n  = 0;
        bc = get_busy(sel) ? 1 : 0;
        while (!get_done(sel) && n < 100) begin
            if (poke && n == 2) begin
                if (sel == 0) begin a8 = 8'h01; b8 = 8'h01; sm8 = ~sm8; end
                else begin a16 = 16'h1; b16 = 16'h1; sm16 = ~sm16; end
                set_start(sel, 1'b1);
            end
            if (poke && n == 3) set_start(sel, 1'b0);
            tick();
            n++;
            if (get_busy(sel)) bc++;
            oe_now = sel ? oe16 : oe8;
            if (n == 4 && oe_now) chk("hold_during_run", get_out(sel), prev_p[sel]);
        end
        chk("latency", 32'(n), 32'(wid(sel) + 1));
        chk("busy_cycles", 32'(bc), 32'(wid(sel) + 1));
    endtask

    task automatic check_res(input int sel, input string tag);
        chk({tag, "_out"}, get_out(sel), exp_p[sel]);
        chk({tag, "_flags"}, {29'h0, get_flags(sel)}, {29'h0, exp_f[sel]});
    endtask

    task automatic op(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input string tag);
        issue(sel, s, a, b);
        wait_done(sel, 1'b0);
        check_res(sel, tag);
        tick();
        chk({tag, "_done_fall"}, {31'h0, get_done(sel)}, 32'h0);
    endtask

    logic [15:0] zz16;
    logic [31:0] zz32;
    logic [2:0]  zz3;
    int          dcnt;

    initial begin
        zz16 = 'z; zz32 = 'z; zz3 = 'z;
        reset = 1'b1; oe8 = 1'b1; oe16 = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        for (int s = 0; s < 2; s++) begin exp_p[s] = '0; exp_f[s] = 3'b001; prev_p[s] = '0; end
        tick(); tick();
        for (int s = 0; s < 2; s++) begin
            chk("rst_busy", {31'h0, get_busy(s)}, 32'h0);
            chk("rst_done", {31'h0, get_done(s)}, 32'h0);
            check_res(s, "rst");
        end
        reset = 1'b0;
        tick();

        // 255x255 with start pokes while busy
        issue(0, 1'b0, 32'hFF, 32'hFF);
        wait_done(0, 1'b1);
        check_res(0, "u255x255");
        chk("u255x255_val", get_out(0), 32'hFE01);
        tick();
        chk("done_fall", {31'h0, get_done(0)}, 32'h0);

        op(0, 1'b1, 32'hFD, 32'h05, "s_m3x5");
        chk("s_m3x5_val", get_out(0), 32'hFFF1);
        op(0, 1'b1, 32'h80, 32'h80, "s_m128sq");
        chk("s_m128sq_flags_val", {29'h0, get_flags(0)}, 32'h4);
        op(0, 1'b1, 32'h80, 32'h01, "s_m128x1");

        // zero product, then back-to-back issue from DONE
        issue(0, 1'b0, 32'h00, 32'h4D);
        wait_done(0, 1'b0);
        check_res(0, "u0x77");
        issue(0, 1'b0, 32'h0C, 32'h0C);
        wait_done(0, 1'b0);
        check_res(0, "b2b_12x12");
        chk("b2b_val", get_out(0), 32'h0090);
        tick();

        // reset during the 4th RUN cycle aborts the operation
        issue(0, 1'b1, 32'hF9, 32'h09);
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        exp_p[0] = '0; exp_f[0] = 3'b001;
        chk("abort_busy", {31'h0, busy8}, 32'h0);
        chk("abort_done", {31'h0, done8}, 32'h0);
        check_res(0, "abort");
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (done8) dcnt++; end
        chk("abort_no_done", 32'(dcnt), 32'h0);

        // output enable gating
        op(0, 1'b1, 32'h64, 32'hF9, "s100xm7");
        oe8 = 1'b0;
        #1;
        chk("oe0_out", get_out(0), {16'h0, zz16});
        chk("oe0_flags", {29'h0, flags8}, {29'h0, zz3});
        tick(); tick();
        oe8 = 1'b1;
        #1;
        check_res(0, "oe_restore");
        oe8 = 1'b0;
        issue(0, 1'b0, 32'hC8, 32'h03);
        wait_done(0, 1'b0);
        chk("oe0_run_out", get_out(0), {16'h0, zz16});
        tick();
        oe8 = 1'b1;
        #1;
        check_res(0, "oe_after_run");

        for (int i = 0; i < 8; i++)
            op(0, 1'(i & 1), $urandom, $urandom, "rnd8");

        // WIDTH=16 sweep, some back-to-back
        op(1, 1'b1, 32'h8000, 32'h8000, "w16_minsq");
        op(1, 1'b0, 32'hFFFF, 32'hFFFF, "w16_maxsq");
        chk("w16_oe_z", {31'h0, (out16 === zz32) || oe16}, 32'h1);
        for (int i = 0; i < 30; i++) begin
            issue(1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            wait_done(1, 1'b0);
            check_res(1, "rnd16");
            if ($urandom_range(0, 2) != 0) tick();
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised, iterative (radix-2 shift-add) multiplier for the execute-stage ALU. It is the next generation of the single-cycle 8x8 unit. It supports a generic operand width and signed or unsigned mode, and uses a start/busy/done handshake so wide multiplies do not sit on the critical path. The product and condition flags are held in registers and driven onto the shared ALU result/flag buses only while output-enable is asserted.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 4..32.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
primary_operand  input  WIDTH  multiplicand; sampled with start
secondary_operand  input  WIDTH  multiplier; sampled with start
oe  input  1  output enable for mult_out and flags
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse when the result register updates
flags  output  3  [0] zero, [1] negative, [2] overflow; high-Z when oe=0
mult_out  output  2*WIDTH  product; high-Z when oe=0

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0.
  - Result register=0 and internal accumulator/counter=0.
  - Flags therefore read 3'b001 when oe=1.
  - Reset has priority over every other input, including mid-operation; the in-flight multiply is discarded.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On start=1: latch the operands and signed_mode.
  - In signed mode, store the magnitudes and sign_neg = msb(a) XOR msb(b); otherwise sign_neg=0.
  - Clear the accumulator, load counter=WIDTH, go to RUN.
  - busy=1 from the same edge.
- RUN, per cycle:
  - If multiplier lsb=1, add the multiplicand to the upper half of the accumulator (WIDTH+1-bit add, carry kept).
  - Shift the accumulator right one bit and decrement the counter.
  - When the counter reaches 1 on this edge, go to FIX after the update.
  - Exactly WIDTH RUN cycles.
- FIX:
  - Result register = sign_neg ? two's-complement negation of the accumulator : accumulator.
  - busy=0, done=1, go to DONE.
- DONE:
  - Lasts one cycle; done falls at the next edge.
  - start=1 in DONE is accepted as in IDLE (back-to-back issue, zero bubble); otherwise go to IDLE.
- Latency: start sampled at edge k produces result and done=1 after edge k+WIDTH+1 (9 cycles for WIDTH=8).
- start while busy (RUN/FIX) is ignored; operands are not re-sampled.
- The result register changes only in FIX; the previous product stays visible during RUN.
- Arithmetic and magnitude rules:
  - Magnitude of the most-negative value (e.g. -128 for WIDTH=8) is the unsigned pattern 2^(WIDTH-1). It is treated unsigned, so no internal overflow occurs.
  - The 2*WIDTH product is always exact.
- Flags are combinational from the result register:
  - zero = (result == 0).
  - negative = result[2*WIDTH-1] in both modes.
  - overflow, unsigned mode: result[2*WIDTH-1:WIDTH] != 0.
  - overflow, signed mode: the upper half is not the sign-extension of result[WIDTH-1].
  - Overflow uses the latched signed_mode of the last completed operation.
- oe=0: flags and mult_out are high-Z. oe has no effect on internal state.

Decomposition:
- Shared header (included by the ALU and this block):
  - State encoding localparams ST_IDLE, ST_RUN, ST_FIX, ST_DONE (2 bits).
  - Flag bit-index constants FLAG_ZERO=0, FLAG_NEG=1, FLAG_OVF=2.
- Sub-module mult_flag_gen(WIDTH): combinational zero/negative/overflow from the result and mode. The ALU's other units will reuse it.
- Control FSM and datapath stay in seq_multiplier.

Test Plan:
- WIDTH=8, unsigned, 255 x 255, start one cycle: done after 9 cycles; mult_out=0xFE01, flags=3'b110. busy is high for exactly 9 cycles and start pulses during busy are ignored.
- Signed, -3 (0xFD) x 5: mult_out=0xFFF1, flags=3'b010.
- Signed -128 x -128 -> 0x4000, flags=3'b100. Then signed -128 x 1 -> 0xFF80, flags=3'b010.
- Unsigned 0 x 77 -> 0x0000, flags=3'b001. Then start asserted in the DONE cycle with 12 x 12: second done exactly 9 cycles later, 0x0090.
- reset=1 during the 4th RUN cycle: the next edge gives busy=0, done=0, mult_out=0, flags=3'b001, and done never pulses for the aborted operation.
- oe=0 at any point -> mult_out and flags all Z. Re-raise oe -> the held result reappears unchanged. Repeat a random signed/unsigned sweep at WIDTH=16 against a reference model.
